sw_led_ctrl: RTL and testbench

//  Board-level switch-to-LED controller, parametrised successor to the plain sw->ld passthrough.

---
 rtl/sw_led_ctrl.sv | 139 +++++++++++++
 tb/tb_sw_led_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: synchronises and debounces WIDTH slide switches,
// detects debounced rising edges and drives WIDTH LEDs in one of four
// patterns (passthrough, toggle-latch, blink, chase) selected by mode.
module sw_led_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DEB_CNT   = 1000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] ld,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise
);

  localparam int DW = $clog2(DEB_CNT);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [DW-1:0]    DEB_LAST   = DW'(DEB_CNT - 1);
  localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [WIDTH-1:0] CHASE_INIT = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_CHASE  = 2'b11
  } mode_t;

  mode_t            mode_sel;
  mode_t            mode_q;
  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_q;
  logic [DW-1:0]    deb_cnt [WIDTH];
  logic [WIDTH-1:0] db_prev;
  logic [BW-1:0]    blink_cnt;
  logic             blink;
  logic             tick;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] chase;
  logic [WIDTH-1:0] chase_rot;
  logic [WIDTH-1:0] chase_view;
  logic             enter_chase;

  assign mode_sel    = mode_t'(mode);
  assign tick        = (blink_cnt == BLINK_LAST);
  assign enter_chase = (mode_sel == MODE_CHASE) && (mode_q != MODE_CHASE);
  // Shift/OR form keeps WIDTH==1 legal: the single bit rotates onto itself.
  assign chase_rot   = (chase << 1) | (chase >> (WIDTH - 1));
  // On the entry cycle show the reloaded position, not the stale register.
  assign chase_view  = enter_chase ? CHASE_INIT : chase;

  // Two-flop synchroniser for the asynchronous switch pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_1 <= '0;
      sync_q <= '0;
    end else begin
      sync_1 <= sw;
      sync_q <= sync_1;
    end
  end

  // Per-bit debounce: accept a new level only after DEB_CNT mismatching cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
      sw_db <= '0;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == sw_db[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          sw_db[i]   <= sync_q[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Registered 0->1 edge detect on the debounced levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= '0;
      sw_rise <= '0;
    end else begin
      db_prev <= sw_db;
      sw_rise <= sw_db & ~db_prev;
    end
  end

  // Free-running blink divider and blink phase flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      blink_cnt <= tick ? '0 : blink_cnt + BW'(1);
      blink     <= blink ^ tick;
    end
  end

  // Toggle latch flips on every debounced press, independent of mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tog <= '0;
    else     tog <= tog ^ sw_rise;
  end

  // Chase position: reload on entry to chase mode, otherwise rotate on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chase  <= CHASE_INIT;
      mode_q <= MODE_PASS;
    end else begin
      mode_q <= mode_sel;
      if (enter_chase) chase <= CHASE_INIT;
      else if (tick)   chase <= chase_rot;
    end
  end

  // LED output register, pattern selected by mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld <= '0;
    end else begin
      case (mode_sel)
        MODE_PASS:   ld <= sw_db;
        MODE_TOGGLE: ld <= tog;
        MODE_BLINK:  ld <= sw_db & {WIDTH{blink}};
        MODE_CHASE:  ld <= chase_view & sw_db;
        default:     ld <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Testbench for sw_led_ctrl with WIDTH=4, DEB_CNT=4, BLINK_DIV=4.
module tb_sw_led_ctrl;

  localparam int W = 4;
  localparam int D = 4;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic [1:0]   mode;
  logic [W-1:0] ld;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;

  int checks = 0;
  int errors = 0;

  sw_led_ctrl #(.WIDTH(W), .DEB_CNT(D), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .sw(sw), .mode(mode),
    .ld(ld), .sw_db(sw_db), .sw_rise(sw_rise)
  );

  always #5 clk = ~clk;

  // Reference model: history of sampled switches, mismatch run lengths,
  // edge/cycle counters and a chase position index.
  logic [W-1:0] m_h0, m_h1, m_db, m_dbp, m_rise, m_tog, m_ld;
  int           m_run [W];
  int           m_k, m_pos;
  logic [1:0]   m_pmode;

  typedef struct {
    logic [W-1:0] sw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] ld;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h0 = '0; m_h1 = '0; m_db = '0; m_dbp = '0; m_rise = '0; m_tog = '0; m_ld = '0;
    for (int b = 0; b < W; b++) m_run[b] = 0;
    m_k = 0; m_pos = 0; m_pmode = 2'b00;
  endtask

  task automatic model_edge();
    logic [W-1:0] ndb, nrise, nld;
    bit blink_b, tick, entering;
    ndb = m_db;
    for (int b = 0; b < W; b++) begin
      if (m_h1[b] != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          ndb[b]   = m_h1[b];
          m_run[b] = 0;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    blink_b  = ((m_k / B) % 2) == 1;
    tick     = (m_k % B) == (B - 1);
    entering = (mode == 2'b11) && (m_pmode != 2'b11);
    case (mode)
      2'b00:   nld = m_db;
      2'b01:   nld = m_tog;
      2'b10:   nld = blink_b ? m_db : '0;
      default: nld = (entering ? W'(1) : W'(1 << m_pos)) & m_db;
    endcase
    if (entering)  m_pos = 0;
    else if (tick) m_pos = (m_pos + 1) % W;
    nrise   = m_db & ~m_dbp;
    m_tog   = m_tog ^ m_rise;
    m_rise  = nrise;
    m_dbp   = m_db;
    m_db    = ndb;
    m_ld    = nld;
    m_h1    = m_h0;
    m_h0    = sw;
    m_k++;
    m_pmode = mode;
  endtask

  // One clock: advance model at the edge, compare outputs 1 time unit later
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_ld",   ld,      m_ld);
    check("model_db",   sw_db,   m_db);
    check("model_rise", sw_rise, m_rise);
  endtask

  // Async reset mid-cycle; outputs must clear at once and stay clear
  task automatic apply_reset(input int n);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_ld", ld, '0);
    check("rst_async_db", sw_db, '0);
    repeat (n) @(posedge clk);
    #1;
    check("rst_hold_ld",   ld,      '0);
    check("rst_hold_rise", sw_rise, '0);
    rst = 1'b0;
  endtask

  task automatic add_rows(input int n, input logic [W-1:0] s, input logic [W-1:0] db,
                          input logic [W-1:0] rise, input logic [W-1:0] l);
    vec_t v;
    v.sw = s; v.db = db; v.rise = rise; v.ld = l;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] chase_a [16];
    logic [W-1:0] chase_b [16];
    logic [W-1:0] flip;

    // Reset with all switches on: nothing propagates while held or before debounce
    rst = 1'b1; sw = 4'hF; mode = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ld",   ld,      4'h0);
    check("rst_db",   sw_db,   4'h0);
    check("rst_rise", sw_rise, 4'h0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("rst_deb_wait_db", sw_db, 4'h0);
      check("rst_deb_wait_ld", ld,    4'h0);
    end
    step();
    check("rst_deb_done_db", sw_db, 4'hF);

    // Table: glitch on sw[0], passthrough of 5, then release (no rise on 1->0)
    sw = 4'h0;
    apply_reset(2);
    add_rows(3, 4'h1, 4'h0, 4'h0, 4'h0);
    add_rows(6, 4'h0, 4'h0, 4'h0, 4'h0);
    add_rows(5, 4'h5, 4'h0, 4'h0, 4'h0);
    add_rows(1, 4'h5, 4'h5, 4'h0, 4'h0);
    add_rows(1, 4'h5, 4'h5, 4'h5, 4'h5);
    add_rows(3, 4'h5, 4'h5, 4'h0, 4'h5);
    add_rows(5, 4'h0, 4'h5, 4'h0, 4'h5);
    add_rows(1, 4'h0, 4'h0, 4'h0, 4'h5);
    add_rows(3, 4'h0, 4'h0, 4'h0, 4'h0);
    foreach (tbl[i]) begin
      sw = tbl[i].sw;
      step();
      check("tbl_db",   sw_db,   tbl[i].db);
      check("tbl_rise", sw_rise, tbl[i].rise);
      check("tbl_ld",   ld,      tbl[i].ld);
    end

    // Toggle: two presses of sw[2]
    sw = 4'h0; mode = 2'b01;
    apply_reset(2);
    sw = 4'h4;
    repeat (8) step();
    check("tog_not_yet", ld, 4'h0);
    sw = 4'h0;
    repeat (8) step();
    check("tog_press1", ld, 4'h4);
    sw = 4'h4;
    repeat (8) step();
    sw = 4'h0;
    repeat (8) step();
    check("tog_press2", ld, 4'h0);

    // Blink: 4-cycle phases once all switches are debounced on
    sw = 4'hF; mode = 2'b10;
    apply_reset(2);
    repeat (8) step();
    for (int k = 9; k <= 24; k++) begin
      step();
      check("blink", ld, (((k - 9) / 4) % 2 == 0) ? 4'h0 : 4'hF);
    end

    // Chase: full pattern, masked pattern, re-entry restart, reset mid-chase
    chase_a = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h8, 4'h8, 4'h8, 4'h8,
                4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2};
    chase_b = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0};
    sw = 4'hF; mode = 2'b11;
    apply_reset(2);
    repeat (8) step();
    for (int i = 0; i < 16; i++) begin
      step();
      check("chase_full", ld, chase_a[i]);
    end
    sw = 4'h5;
    repeat (8) step();
    check("chase_db5", sw_db, 4'h5);
    for (int i = 0; i < 16; i++) begin
      step();
      check("chase_masked", ld, chase_b[i]);
    end
    mode = 2'b00;
    repeat (5) step();
    check("chase_exit_pass", ld, 4'h5);
    mode = 2'b11;
    step();
    check("chase_reenter0", ld, 4'h1);
    step();
    check("chase_reenter1", ld, 4'h1);
    step();
    check("chase_reenter2", ld, 4'h1);
    step();
    check("chase_reenter3", ld, 4'h0);
    apply_reset(1);
    repeat (12) step();

    // Random switches and modes against the model, with one reset mid-run
    for (int i = 0; i < 3000; i++) begin
      flip = '0;
      for (int b = 0; b < W; b++) flip[b] = ($urandom_range(0, 5) == 0);
      sw = sw ^ flip;
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if (i == 1500) apply_reset(1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
